shared_resource_rr_arbiter: RTL and testbench

- Parametrised successor to the two-pipeline shared-resource arrangement: N requesting pipelines share one fixed-latency resource through a round-robin arbiter.
- Each transaction carries an owner tag through the resource pipeline, and the result is returned only to the requesting channel.
- Per-channel stall and per-channel flush; a flush on one channel kills only that channel's in-flight work.
- Sits between N pipeline_top-style requesters and the shared datapath.

---
 rtl/shared_resource_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_shared_resource_rr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_resource_rr_arbiter.sv
// Round-robin arbiter in front of a shared fixed-latency resource.
// N_CH requesters compete for one issue slot per cycle. Each accepted
// transaction carries its owner tag down the resource pipeline, and the
// result is returned only on that owner's response slice. A per-channel
// flush kills that channel's in-flight entries without disturbing others.
module shared_resource_rr_arbiter #(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int OP_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH*DATA_W-1:0]   req_data,
  input  logic [N_CH-1:0]          flush,
  output logic [N_CH-1:0]          req_ready,
  output logic [N_CH-1:0]          stall,
  output logic [N_CH-1:0]          rsp_valid,
  output logic [N_CH*DATA_W-1:0]   rsp_data
);

  localparam int TAG_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  tag_t            rr_ptr;
  logic [N_CH-1:0] eligible;
  logic            grant_any;
  tag_t            grant_idx;
  entry_t          new_entry;
  entry_t          last_in;   // entry that lands in the response register next edge

  // The resource operation, applied once as the operand enters the pipeline.
  function automatic logic [DATA_W-1:0] apply_op(input logic [DATA_W-1:0] x);
    case (OP_MODE)
      1:       return x + DATA_W'(1);
      2:       return ~x;
      default: return x;
    endcase
  endfunction

  // Drop an entry whose owner is being flushed this cycle.
  function automatic entry_t kill(input entry_t e, input logic [N_CH-1:0] f);
    entry_t r;
    r       = e;
    r.valid = e.valid & ~f[e.tag];
    return r;
  endfunction

  assign eligible = req_valid & ~flush;

  // Scan eligible channels starting at rr_ptr; first hit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(rr_ptr) + k) % N_CH;
      if (!grant_any && !reset && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = tag_t'(idx);
      end
    end
  end

  // One-hot ready from the grant; stall is a requester that was not served.
  always_comb begin
    req_ready = '0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  assign stall = req_valid & ~req_ready;

  // Build the entry that enters the first pipeline stage; bubbles are all-zero.
  always_comb begin
    new_entry = '0;
    if (grant_any) begin
      new_entry.valid = 1'b1;
      new_entry.tag   = grant_idx;
      new_entry.data  = apply_op(req_data[int'(grant_idx)*DATA_W +: DATA_W]);
    end
  end

  // Round-robin pointer moves past the channel just served, holds otherwise.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(grant_idx) == N_CH - 1) ? '0 : tag_t'(grant_idx + 1'b1);
    end
  end

  if (LATENCY > 1) begin : g_pipe
    entry_t pipe_q [LATENCY-1];

    // Intermediate stages; flushed owners are killed on every hop.
    always_ff @(posedge clk) begin
      // NOTE: only the valid bits matter functionally, but the whole stage is
      // cleared so bubbles carry zero data and simulation never sees X.
      if (reset) begin
        for (int s = 0; s < LATENCY - 1; s++) pipe_q[s] <= '0;
      end else begin
        pipe_q[0] <= new_entry;
        for (int s = 1; s < LATENCY - 1; s++) pipe_q[s] <= kill(pipe_q[s-1], flush);
      end
    end

    // The deepest intermediate stage feeds the response register.
    always_comb last_in = kill(pipe_q[LATENCY-2], flush);
  end else begin : g_direct
    // Single-cycle resource: the new entry goes straight to the response register.
    always_comb last_in = new_entry;
  end

  // Final stage, kept in expanded form: only the owner's slice is driven.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rsp_valid[i]                  <= last_in.valid && (int'(last_in.tag) == i);
        rsp_data[i*DATA_W +: DATA_W] <= (last_in.valid && (int'(last_in.tag) == i))
                                        ? last_in.data : '0;
      end
    end
  end

endmodule

// File: tb/tb_shared_resource_rr_arbiter.sv
// Bench for shared_resource_rr_arbiter. Two instances: a 4-channel,
// 3-deep increment resource and a 2-channel, 2-deep invert resource.
// Stimulus pushes expected responses into per-instance queues; monitors
// pop and compare whenever a response appears.
module tb_shared_resource_rr_arbiter;

  localparam int N1 = 4, LAT1 = 3;
  localparam int N2 = 2, LAT2 = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N1-1:0]    req_valid = '0, flush = '0;
  logic [N1*DW-1:0] req_data = '0;
  logic [N1-1:0]    req_ready, stall, rsp_valid;
  logic [N1*DW-1:0] rsp_data;

  logic [N2-1:0]    req_valid2 = '0, flush2 = '0;
  logic [N2*DW-1:0] req_data2 = '0;
  logic [N2-1:0]    req_ready2, stall2, rsp_valid2;
  logic [N2*DW-1:0] rsp_data2;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  shared_resource_rr_arbiter #(.N_CH(N1), .DATA_W(DW), .LATENCY(LAT1), .OP_MODE(1)) u_inc (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .flush(flush),
    .req_ready(req_ready), .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  shared_resource_rr_arbiter #(.N_CH(N2), .DATA_W(DW), .LATENCY(LAT2), .OP_MODE(2)) u_inv (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_data(req_data2), .flush(flush2),
    .req_ready(req_ready2), .stall(stall2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Monitor for the increment instance.
  always @(negedge clk) begin
    exp_t         e;
    logic [127:0] ed;
    if (rsp_valid !== '0) begin
      if (q1.size() == 0) begin
        check("inc unexpected rsp_valid", 128'(rsp_valid), 128'd0);
      end else begin
        e  = q1.pop_front();
        ed = '0;
        ed[e.ch*32 +: 32] = e.data;
        check("inc rsp cycle", 128'(cycle), 128'(e.at));
        check("inc rsp_valid", 128'(rsp_valid), 128'(1) << e.ch);
        check("inc rsp_data", rsp_data, ed);
      end
    end else begin
      check("inc idle rsp_data", rsp_data, 128'd0);
    end
  end

  // Monitor for the invert instance.
  always @(negedge clk) begin
    exp_t         e;
    logic [127:0] ed;
    if (rsp_valid2 !== '0) begin
      if (q2.size() == 0) begin
        check("inv unexpected rsp_valid", 128'(rsp_valid2), 128'd0);
      end else begin
        e  = q2.pop_front();
        ed = '0;
        ed[e.ch*32 +: 32] = e.data;
        check("inv rsp cycle", 128'(cycle), 128'(e.at));
        check("inv rsp_valid", 128'(rsp_valid2), 128'(1) << e.ch);
        check("inv rsp_data", 128'(rsp_data2), ed);
      end
    end else begin
      check("inv idle rsp_data", 128'(rsp_data2), 128'd0);
    end
  end

  // One cycle on the increment instance with the hand-computed grant.
  task automatic step(input logic [3:0] v, input logic [127:0] d, input logic [3:0] f,
                      input logic [3:0] exp_rdy, input bit push);
    req_valid = v;
    req_data  = d;
    flush     = f;
    @(negedge clk);
    check("inc req_ready", 128'(req_ready), 128'(exp_rdy));
    check("inc stall", 128'(stall), 128'(v & ~exp_rdy));
    if (push)
      for (int i = 0; i < N1; i++)
        if (exp_rdy[i]) q1.push_back('{i, d[i*32 +: 32] + 32'd1, cycle + LAT1});
    @(posedge clk);
    #1;
  endtask

  // One cycle on the invert instance with the hand-computed grant.
  task automatic step2(input logic [1:0] v, input logic [63:0] d, input logic [1:0] f,
                       input logic [1:0] exp_rdy, input bit push);
    req_valid2 = v;
    req_data2  = d;
    flush2     = f;
    @(negedge clk);
    check("inv req_ready", 128'(req_ready2), 128'(exp_rdy));
    check("inv stall", 128'(stall2), 128'(v & ~exp_rdy));
    if (push)
      for (int i = 0; i < N2; i++)
        if (exp_rdy[i]) q2.push_back('{i, ~d[i*32 +: 32], cycle + LAT2});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, '0, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic do_reset(input int n, input logic [3:0] v);
    reset     = 1'b1;
    req_valid = v;
    flush     = '0;
    repeat (n) begin
      @(negedge clk);
      check("inc req_ready in reset", 128'(req_ready), 128'd0);
      check("inv req_ready in reset", 128'(req_ready2), 128'd0);
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    logic [127:0] d;

    // Reset then idle: nothing ready, nothing returned.
    do_reset(3, 4'b0000);
    idle(3);

    // Round robin from pointer 0 with all four requesting.
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < N1; c++) d[c*32 +: 32] = 32'hA000_0000 | 32'(k << 8) | 32'(c);
      step(4'b1111, d, 4'b0000, 4'(1 << (k % 4)), 1'b1);
    end
    idle(LAT1 + 1);

    // Single request on ch0 (pointer 0): 5 -> 6.
    d = '0; d[31:0] = 32'h0000_0005;
    step(4'b0001, d, 4'b0000, 4'b0001, 1'b1);
    idle(LAT1 + 1);

    // Wrap on ch1 (pointer 1): all-ones + 1 -> 0.
    d = '0; d[63:32] = 32'hFFFF_FFFF;
    step(4'b0010, d, 4'b0000, 4'b0010, 1'b1);
    idle(LAT1 + 1);

    // Pointer 2, ch0 and ch2 requesting: ch2 first, then ch0 (pointer wraps).
    d = '0; d[31:0] = 32'h1234_5678; d[95:64] = 32'h0BAD_F00D;
    step(4'b0101, d, 4'b0000, 4'b0100, 1'b1);
    step(4'b0101, d, 4'b0000, 4'b0001, 1'b1);
    idle(LAT1 + 1);

    // Selective flush (pointer 1): ch0 at t killed by flush[0] at t+1; ch1 survives.
    d = '0; d[31:0] = 32'h0000_0100; d[63:32] = 32'h0000_0200;
    step(4'b0001, d, 4'b0000, 4'b0001, 1'b0);
    step(4'b0010, d, 4'b0001, 4'b0010, 1'b1);
    idle(LAT1 + 1);

    // Flushed channel is not granted even though it requests (pointer 2).
    step(4'b0011, d, 4'b0001, 4'b0010, 1'b1);
    idle(LAT1 + 1);

    // Flush one cycle before the output stage (pointer 2): no response.
    step(4'b0001, d, 4'b0000, 4'b0001, 1'b0);
    idle(1);
    step(4'b0000, d, 4'b0001, 4'b0000, 1'b0);
    idle(LAT1 + 1);

    // Reset mid-flight (pointer 1): only the response already registered
    // when reset rises is seen; the other two are discarded.
    d = '0; d[31:0] = 32'h0000_0010; d[63:32] = 32'h0000_0020; d[95:64] = 32'h0000_0030;
    step(4'b0001, d, 4'b0000, 4'b0001, 1'b1);
    step(4'b0010, d, 4'b0000, 4'b0010, 1'b0);
    step(4'b0100, d, 4'b0000, 4'b0100, 1'b0);
    do_reset(1, 4'b1111);
    idle(5);
    d[127:96] = 32'h0000_0040;
    step(4'b1111, d, 4'b0000, 4'b0001, 1'b1);
    idle(LAT1 + 1);

    // Invert instance: 0x0F0F_0000 -> 0xF0F0_FFFF, then contention from pointer 1.
    step2(2'b01, {32'h0, 32'h0F0F_0000}, 2'b00, 2'b01, 1'b1);
    step2(2'b11, {32'h0000_0000, 32'h5555_AAAA}, 2'b00, 2'b10, 1'b1);
    step2(2'b11, {32'h0000_0000, 32'h5555_AAAA}, 2'b00, 2'b01, 1'b1);
    step2(2'b00, '0, 2'b00, 2'b00, 1'b0);
    repeat (LAT2 + 1) step2(2'b00, '0, 2'b00, 2'b00, 1'b0);

    check("inc queue drained", 128'(q1.size()), 128'd0);
    check("inv queue drained", 128'(q2.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
